interrupt_sequencer: RTL and testbench

- CPU-side responder for the interrupt handler's request lines.
- Accepts the registered interrupt request and its 5-bit number, and waits for an instruction boundary.
- Saves the return PC, redirects fetch to a vector, and tracks in-service state.
- On return-from-interrupt, restores the PC and re-arms the handler with an enable pulse. Also turns software EI/DI instructions into handler enable/disable pulses.

---
 rtl/interrupt_sequencer_if.sv | 34 +++
 rtl/interrupt_sequencer.sv | 90 +++++++++
 tb/tb_interrupt_sequencer.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/interrupt_sequencer_if.sv
// Request/redirect bundle between the CPU + interrupt handler (master) and the
// interrupt sequencer (slave).
interface interrupt_sequencer_if #(
    parameter int ADDR_W = 16
);
    logic              irq_in;
    logic [4:0]        irq_num;
    logic              instr_boundary;
    logic [ADDR_W-1:0] pc_current;
    logic              reti;
    logic              ei_instr;
    logic              di_instr;
    logic              cpu_stall;
    logic              pc_load;
    logic [ADDR_W-1:0] pc_load_value;
    logic              flush;
    logic              enable_interrupts;
    logic              disable_interrupts;
    logic              in_service;
    logic [4:0]        cause;
    logic [ADDR_W-1:0] epc;

    modport master (
        output irq_in, irq_num, instr_boundary, pc_current, reti, ei_instr, di_instr,
        input  cpu_stall, pc_load, pc_load_value, flush, enable_interrupts,
               disable_interrupts, in_service, cause, epc
    );

    modport slave (
        input  irq_in, irq_num, instr_boundary, pc_current, reti, ei_instr, di_instr,
        output cpu_stall, pc_load, pc_load_value, flush, enable_interrupts,
               disable_interrupts, in_service, cause, epc
    );
endinterface

// File: rtl/interrupt_sequencer.sv
// Takes a latched interrupt at an instruction boundary, redirects fetch to its
// vector, tracks the ISR and restores the PC on reti; also maps EI/DI to pulses.
module interrupt_sequencer #(
    parameter int                ADDR_W       = 16,
    parameter logic [ADDR_W-1:0] VECTOR_BASE  = 16'h0040,
    parameter int                VECTOR_SHIFT = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    interrupt_sequencer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, PENDING, VECTOR, SERVICE, RETURN} state_t;

    state_t            state;
    logic [ADDR_W-1:0] vector_addr;

    // Wraps modulo 2^ADDR_W by construction of the operand widths.
    assign vector_addr = VECTOR_BASE + (ADDR_W'(bus.cause) << VECTOR_SHIFT);

    // Outputs are registered together with the state, so each one reflects the
    // state being entered and never depends combinationally on an input.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state                  <= IDLE;
            bus.cause              <= '0;
            bus.epc                <= '0;
            bus.cpu_stall          <= 1'b0;
            bus.flush              <= 1'b0;
            bus.pc_load            <= 1'b0;
            bus.pc_load_value      <= '0;
            bus.in_service         <= 1'b0;
            bus.enable_interrupts  <= 1'b0;
            bus.disable_interrupts <= 1'b0;
        end else begin
            // NOTE: defaults first, then the case overrides; non-blocking
            // assignments make the last write in program order win.
            bus.cpu_stall     <= 1'b0;
            bus.flush         <= 1'b0;
            bus.pc_load       <= 1'b0;
            bus.pc_load_value <= '0;
            bus.in_service    <= 1'b0;

            // DI wins over both a software EI and the re-arm issued on return.
            bus.disable_interrupts <= bus.di_instr;
            bus.enable_interrupts  <= !bus.di_instr &&
                                      ((bus.ei_instr && state != SERVICE) ||
                                       (state == SERVICE && bus.reti));

            case (state)
                IDLE: begin
                    if (bus.irq_in) begin
                        bus.cause <= bus.irq_num;
                        state     <= PENDING;
                    end
                end
                PENDING: begin
                    if (bus.instr_boundary) begin
                        bus.epc           <= bus.pc_current;
                        bus.cpu_stall     <= 1'b1;
                        bus.flush         <= 1'b1;
                        bus.pc_load       <= 1'b1;
                        bus.pc_load_value <= vector_addr;
                        state             <= VECTOR;
                    end
                end
                VECTOR: begin
                    bus.in_service <= 1'b1;
                    state          <= SERVICE;
                end
                SERVICE: begin
                    if (bus.reti) begin
                        bus.cpu_stall     <= 1'b1;
                        bus.flush         <= 1'b1;
                        bus.pc_load       <= 1'b1;
                        bus.pc_load_value <= bus.epc;
                        state             <= RETURN;
                    end else begin
                        bus.in_service <= 1'b1;
                    end
                end
                RETURN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed and randomized stimulus for interrupt_sequencer, compared every cycle
// against a transaction-level model of the interrupt entry/return sequence.
module tb_interrupt_sequencer;
    localparam int ADDR_W = 16;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    interrupt_sequencer_if #(.ADDR_W(ADDR_W)) bus ();
    interrupt_sequencer_if #(.ADDR_W(ADDR_W)) wbus ();

    interrupt_sequencer #(.ADDR_W(ADDR_W), .VECTOR_BASE(16'h0040), .VECTOR_SHIFT(2)) dut (
        .clock(clock), .reset(reset), .bus(bus)
    );
    interrupt_sequencer #(.ADDR_W(ADDR_W), .VECTOR_BASE(16'hFFF0), .VECTOR_SHIFT(2)) dut_wrap (
        .clock(clock), .reset(reset), .bus(wbus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Model: which step of the interrupt sequence the CPU is in.
    localparam int M_IDLE = 0, M_WAIT_BOUNDARY = 1, M_JUMP = 2, M_ISR = 3, M_RESUME = 4;
    int          m_step;
    logic [4:0]  m_cause;
    logic [15:0] m_epc;
    logic        e_stall, e_flush, e_load, e_en, e_dis, e_svc;
    logic [15:0] e_value;

    function automatic logic [15:0] vector_of(input int base, input int num);
        return 16'((base + num * 4) % 65536);
    endfunction

    task automatic model_reset();
        m_step = M_IDLE; m_cause = '0; m_epc = '0;
        e_stall = 0; e_flush = 0; e_load = 0; e_en = 0; e_dis = 0; e_svc = 0; e_value = '0;
    endtask

    task automatic model_advance(input logic irq, input logic [4:0] num, input logic bnd,
                                 input logic [15:0] pc, input logic rt, input logic ei, input logic di);
        int nxt = m_step;
        if (m_step == M_IDLE && irq) begin nxt = M_WAIT_BOUNDARY; m_cause = num; end
        else if (m_step == M_WAIT_BOUNDARY && bnd) begin nxt = M_JUMP; m_epc = pc; end
        else if (m_step == M_JUMP) nxt = M_ISR;
        else if (m_step == M_ISR && rt) nxt = M_RESUME;
        else if (m_step == M_RESUME) nxt = M_IDLE;
        e_en    = !di && ((ei && m_step != M_ISR) || nxt == M_RESUME);
        e_dis   = di;
        e_stall = (nxt == M_JUMP || nxt == M_RESUME);
        e_flush = e_stall;
        e_load  = e_stall;
        e_value = (nxt == M_JUMP) ? vector_of(16'h0040, int'(m_cause)) :
                  (nxt == M_RESUME) ? m_epc : 16'h0000;
        e_svc   = (nxt == M_ISR);
        m_step  = nxt;
    endtask

    task automatic check_outputs();
        check("cpu_stall", 32'(bus.cpu_stall), 32'(e_stall));
        check("flush", 32'(bus.flush), 32'(e_flush));
        check("pc_load", 32'(bus.pc_load), 32'(e_load));
        check("pc_load_value", 32'(bus.pc_load_value), 32'(e_value));
        check("enable_interrupts", 32'(bus.enable_interrupts), 32'(e_en));
        check("disable_interrupts", 32'(bus.disable_interrupts), 32'(e_dis));
        check("in_service", 32'(bus.in_service), 32'(e_svc));
        check("cause", 32'(bus.cause), 32'(m_cause));
        check("epc", 32'(bus.epc), 32'(m_epc));
    endtask

    task automatic drive(input logic irq, input logic [4:0] num, input logic bnd,
                         input logic [15:0] pc, input logic rt, input logic ei, input logic di);
        bus.irq_in = irq; bus.irq_num = num; bus.instr_boundary = bnd;
        bus.pc_current = pc; bus.reti = rt; bus.ei_instr = ei; bus.di_instr = di;
    endtask

    // One clock cycle: check what the last edge produced, then present new inputs.
    task automatic step(input logic irq, input logic [4:0] num, input logic bnd,
                        input logic [15:0] pc, input logic rt, input logic ei, input logic di);
        @(negedge clock);
        check_outputs();
        drive(irq, num, bnd, pc, rt, ei, di);
        model_advance(irq, num, bnd, pc, rt, ei, di);
    endtask

    task automatic idle();
        step(1'b0, 5'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    endtask

    // Asynchronous reset in the middle of the low clock phase.
    task automatic do_reset();
        #2;
        reset = 1'b1;
        drive(1'b0, 5'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        #1;
        model_reset();
        check_outputs();
        @(negedge clock);
        reset = 1'b0;
        model_advance(1'b0, 5'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        drive(1'b0, 5'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        wbus.irq_in = 0; wbus.irq_num = 0; wbus.instr_boundary = 0; wbus.pc_current = 0;
        wbus.reti = 0; wbus.ei_instr = 0; wbus.di_instr = 0;
        @(negedge clock);
        do_reset();

        // Vector address wrap on the FFF0-based instance.
        idle();
        wbus.irq_in = 1'b1; wbus.irq_num = 5'd31;
        idle();
        wbus.irq_in = 1'b0; wbus.instr_boundary = 1'b1; wbus.pc_current = 16'h0100;
        idle();
        wbus.instr_boundary = 1'b0;
        check("wrap_pc_load", 32'(wbus.pc_load), 32'd1);
        check("wrap_pc_load_value", 32'(wbus.pc_load_value), 32'h006C);

        // Minimum-latency entry, ignored nested irq, and return.
        step(1'b1, 5'd5, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        step(1'b0, 5'd0, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b0);
        idle();
        check("vec_pc_load_value", 32'(bus.pc_load_value), 32'h0054);
        check("vec_flush", 32'(bus.flush), 32'd1);
        step(1'b1, 5'd3, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        check("isr_in_service", 32'(bus.in_service), 32'd1);
        check("isr_epc", 32'(bus.epc), 32'h1234);
        step(1'b0, 5'd0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        check("nested_cause", 32'(bus.cause), 32'd5);
        check("nested_no_vector", 32'(bus.pc_load), 32'd0);
        idle();
        check("ret_pc_load_value", 32'(bus.pc_load_value), 32'h1234);
        check("ret_enable", 32'(bus.enable_interrupts), 32'd1);
        idle();
        check("after_ret_enable", 32'(bus.enable_interrupts), 32'd0);
        check("after_ret_in_service", 32'(bus.in_service), 32'd0);

        // Long wait for an instruction boundary.
        step(1'b1, 5'd9, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            idle();
            check("pending_no_stall", 32'(bus.cpu_stall), 32'd0);
        end
        step(1'b0, 5'd0, 1'b1, 16'h2000, 1'b0, 1'b0, 1'b0);
        idle();
        check("late_vector", 32'(bus.pc_load_value), 32'h0064);
        idle();

        // Reset while an ISR is running.
        check("pre_reset_in_service", 32'(bus.in_service), 32'd1);
        do_reset();
        idle();
        check("post_reset_enable", 32'(bus.enable_interrupts), 32'd0);
        check("post_reset_epc", 32'(bus.epc), 32'd0);

        // Simultaneous EI and DI.
        step(1'b0, 5'd0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
        idle();
        check("eidi_disable", 32'(bus.disable_interrupts), 32'd1);
        check("eidi_enable", 32'(bus.enable_interrupts), 32'd0);

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) == 0, 5'($urandom), $urandom_range(0, 2) == 0,
                 16'($urandom), $urandom_range(0, 4) == 0,
                 $urandom_range(0, 6) == 0, $urandom_range(0, 6) == 0);
            if ($urandom_range(0, 299) == 0) do_reset();
        end
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
